writeback_stage: RTL and testbench

Parametrised MEM/WB pipeline register and write-back result selector for the pipelined core. Selects one of `NSRC` result sources in the memory stage, extracts and extends sub-word load data, and registers the result with its destination register and write enable into the write-back stage. Supports stall and flush, and keeps a retired-instruction counter. Drives the register-file write port and the WB forwarding path.

---
 rtl/writeback_stage.sv | 91 +++++++++
 tb/tb_writeback_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register with NSRC-way result select; defining WB_LOAD_EXT_EN adds sub-word load extraction.
// Latency: one cycle from M inputs to W outputs; every output is registered.
// Backpressure: StallW holds every register including InstRetW; FlushW kills the slot and wins over StallW.
module writeback_stage #(
  parameter int W    = 32,
  parameter int NSRC = 4,
  parameter int SW   = $clog2(NSRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ValidM,
  input  logic                   StallW,
  input  logic                   FlushW,
  input  logic                   RegWriteM,
  input  logic [4:0]             RdM,
  input  logic [SW-1:0]          ResultSrcM,
  input  logic [NSRC*W-1:0]      SrcDataM,
  input  logic [2:0]             LoadTypeM,
  input  logic [$clog2(W/8)-1:0] ByteOffM,
  output logic [W-1:0]           ResultW,
  output logic [4:0]             RdW,
  output logic                   RegWriteW,
  output logic                   ValidW,
  output logic [31:0]            InstRetW
);

  logic [W-1:0] sel;
  logic [W-1:0] result;
  logic         we;

  // Out-of-range selects never match a loop index, so they fall back to source 0.
  always_comb begin
    sel = SrcDataM[0 +: W];
    for (int k = 1; k < NSRC; k++) begin
      if (ResultSrcM == SW'(k)) begin
        sel = SrcDataM[k*W +: W];
      end
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [W-1:0] ld_shift;
  logic [W-1:0] ld_ext;

  // Misaligned offsets shift zeros in from the top rather than faulting.
  assign ld_shift = SrcDataM[W +: W] >> {ByteOffM, 3'b000};

  always_comb begin
    case (LoadTypeM)
      3'b000:  ld_ext = W'($signed(ld_shift[7:0]));
      3'b001:  ld_ext = W'($signed(ld_shift[15:0]));
      3'b010:  ld_ext = W'($signed(ld_shift[31:0]));
      3'b100:  ld_ext = W'(ld_shift[7:0]);
      3'b101:  ld_ext = W'(ld_shift[15:0]);
      3'b110:  ld_ext = W'(ld_shift[31:0]);
      default: ld_ext = ld_shift;
    endcase
  end

  assign result = (ResultSrcM == SW'(1)) ? ld_ext : sel;
`else
  logic unused_load;

  assign unused_load = ^{LoadTypeM, ByteOffM};
  assign result      = sel;
`endif

  assign we = RegWriteM & ValidM & (|RdM);

  always_ff @(posedge clk) begin
    if (rst) begin
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
      ValidW    <= 1'b0;
      InstRetW  <= '0;
    end else if (FlushW) begin
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
      ValidW    <= 1'b0;
    end else if (!StallW) begin
      ResultW   <= result;
      RdW       <= RdM;
      RegWriteW <= we;
      ValidW    <= ValidM;
      InstRetW  <= InstRetW + 32'(ValidM);
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_writeback_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ValidM, StallW, FlushW, RegWriteM;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  LoadTypeM;
  logic [1:0]  ByteOffM;
  logic [31:0] src [4];
  logic [127:0] SrcDataM;
  logic [95:0]  SrcDataM3;

  assign SrcDataM  = {src[3], src[2], src[1], src[0]};
  assign SrcDataM3 = {src[2], src[1], src[0]};

  logic [31:0] ResultW, InstRetW, ResultW3, InstRetW3;
  logic [4:0]  RdW, RdW3;
  logic        RegWriteW, ValidW, RegWriteW3, ValidW3;

  writeback_stage #(.W(32), .NSRC(4)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .StallW(StallW), .FlushW(FlushW),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .SrcDataM(SrcDataM),
    .LoadTypeM(LoadTypeM), .ByteOffM(ByteOffM), .ResultW(ResultW), .RdW(RdW),
    .RegWriteW(RegWriteW), .ValidW(ValidW), .InstRetW(InstRetW)
  );

  // Three sources, so select 3 is illegal here.
  writeback_stage #(.W(32), .NSRC(3)) dut3 (
    .clk(clk), .rst(rst), .ValidM(ValidM), .StallW(StallW), .FlushW(FlushW),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .SrcDataM(SrcDataM3),
    .LoadTypeM(LoadTypeM), .ByteOffM(ByteOffM), .ResultW(ResultW3), .RdW(RdW3),
    .RegWriteW(RegWriteW3), .ValidW(ValidW3), .InstRetW(InstRetW3)
  );

  // Behavioural model
  logic [31:0] exp_res, exp_res3, exp_cnt;
  logic [4:0]  exp_rd;
  logic        exp_we, exp_vld;
  logic [31:0] base;
  int unsigned n_chk, n_fail;

  function automatic logic [31:0] ld_model(input logic [31:0] rd, input logic [2:0] lt,
                                           input logic [1:0] off);
    logic [31:0] d, b, h;
    d = rd >> (8 * off);
    b = d % 256;
    h = d % 65536;
    case (lt)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] result_model(input int nsrc);
    int idx;
    idx = (int'(ResultSrcM) < nsrc) ? int'(ResultSrcM) : 0;
`ifdef WB_LOAD_EXT_EN
    if (idx == 1) return ld_model(src[1], LoadTypeM, ByteOffM);
`endif
    return src[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_res <= 0; exp_res3 <= 0; exp_rd <= 0; exp_we <= 0; exp_vld <= 0; exp_cnt <= 0;
    end else if (FlushW) begin
      exp_res <= 0; exp_res3 <= 0; exp_rd <= 0; exp_we <= 0; exp_vld <= 0;
    end else if (!StallW) begin
      exp_res  <= result_model(4);
      exp_res3 <= result_model(3);
      exp_rd   <= RdM;
      exp_we   <= RegWriteM && ValidM && (RdM != 5'd0);
      exp_vld  <= ValidM;
      exp_cnt  <= exp_cnt + (ValidM ? 32'd1 : 32'd0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("ResultW",    ResultW,          exp_res);
    chk("RdW",        32'(RdW),         32'(exp_rd));
    chk("RegWriteW",  32'(RegWriteW),   32'(exp_we));
    chk("ValidW",     32'(ValidW),      32'(exp_vld));
    chk("InstRetW",   InstRetW,         exp_cnt + base);
    chk("ResultW3",   ResultW3,         exp_res3);
    chk("RdW3",       32'(RdW3),        32'(exp_rd));
    chk("RegWriteW3", 32'(RegWriteW3),  32'(exp_we));
    chk("ValidW3",    32'(ValidW3),     32'(exp_vld));
    chk("InstRetW3",  InstRetW3,        exp_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic op(input logic v, input logic w, input logic [4:0] rd, input logic [1:0] s);
    ValidM = v; RegWriteM = w; RdM = rd; ResultSrcM = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0]  lt_tab  [4];
  logic [1:0]  off_tab [4];
  logic [31:0] ld_exp  [4];

  initial begin
    n_chk = 0; n_fail = 0; base = 0;
    rst = 1; StallW = 0; FlushW = 0; LoadTypeM = 0; ByteOffM = 0;
    op(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) src[k] = 0;

    step(); step();
    chk("rst ResultW", ResultW, 32'h0);
    chk("rst RdW", 32'(RdW), 32'h0);
    chk("rst RegWriteW", 32'(RegWriteW), 32'h0);
    chk("rst ValidW", 32'(ValidW), 32'h0);
    chk("rst InstRetW", InstRetW, 32'h0);

    rst = 0;
    src[0] = 32'h1234_5678; op(1, 1, 5, 0);
    step();
    chk("alu ResultW", ResultW, 32'h1234_5678);
    chk("alu RdW", 32'(RdW), 32'd5);
    chk("alu RegWriteW", 32'(RegWriteW), 32'd1);
    chk("alu InstRetW", InstRetW, 32'd1);

    lt_tab  = '{3'b000, 3'b100, 3'b001, 3'b101};
    off_tab = '{2'd0, 2'd1, 2'd2, 2'd3};
`ifdef WB_LOAD_EXT_EN
    ld_exp  = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1, 32'h0000_0080};
`else
    ld_exp  = '{32'h80F1_7F82, 32'h80F1_7F82, 32'h80F1_7F82, 32'h80F1_7F82};
`endif
    src[1] = 32'h80F1_7F82;
    for (int i = 0; i < 4; i++) begin
      op(1, 1, 6, 1); LoadTypeM = lt_tab[i]; ByteOffM = off_tab[i];
      step();
      chk("load ResultW", ResultW, ld_exp[i]);
    end

    src[2] = 32'h104; op(1, 1, 8, 2);
    step();
    chk("pc4 ResultW", ResultW, 32'h104);
    src[3] = 32'h2000; op(1, 1, 8, 3);
    step();
    chk("pcimm ResultW", ResultW, 32'h2000);
    chk("illegal sel ResultW3", ResultW3, 32'h1234_5678);

    op(1, 1, 0, 0);
    step();
    chk("x0 RegWriteW", 32'(RegWriteW), 32'd0);
    chk("x0 ValidW", 32'(ValidW), 32'd1);
    chk("x0 InstRetW", InstRetW, 32'd8);

    src[0] = 32'hCAFE_0001; op(1, 1, 7, 0);
    step();
    src[0] = 32'hDEAD_0000; op(1, 1, 9, 0); StallW = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall ResultW", ResultW, 32'hCAFE_0001);
      chk("stall RdW", 32'(RdW), 32'd7);
      chk("stall InstRetW", InstRetW, 32'd9);
    end
    FlushW = 1;
    step();
    chk("flush ValidW", 32'(ValidW), 32'd0);
    chk("flush RegWriteW", 32'(RegWriteW), 32'd0);
    chk("flush ResultW", ResultW, 32'h0);
    chk("flush InstRetW", InstRetW, 32'd9);

    FlushW = 0; StallW = 0;
    step();
    StallW = 1;
    step();
    rst = 1;
    step();
    chk("rst-stall ResultW", ResultW, 32'h0);
    chk("rst-stall RdW", 32'(RdW), 32'h0);
    chk("rst-stall ValidW", 32'(ValidW), 32'h0);
    chk("rst-stall InstRetW", InstRetW, 32'h0);
    rst = 0; StallW = 0;

    for (int c = 0; c < 1500; c++) begin
      ValidM     = ($urandom_range(0, 9) < 8);
      RegWriteM  = 1'($urandom_range(0, 1));
      RdM        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ResultSrcM = 2'($urandom_range(0, 3));
      LoadTypeM  = 3'($urandom_range(0, 7));
      ByteOffM   = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      StallW     = ($urandom_range(0, 4) == 0);
      FlushW     = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      step();
    end

    rst = 0; StallW = 0; FlushW = 0; op(0, 0, 0, 0);
    step();
    // Preload the counter just below the wrap point.
    base = 32'hFFFF_FFFE - exp_cnt;
    force dut.InstRetW = 32'hFFFF_FFFE;
    #1;
    release dut.InstRetW;
    op(1, 1, 3, 0);
    step();
    chk("wrap pre InstRetW", InstRetW, 32'hFFFF_FFFF);
    step();
    chk("wrap InstRetW", InstRetW, 32'h0);
    op(0, 1, 3, 0);
    step();
    chk("bubble InstRetW", InstRetW, 32'h0);
    chk("bubble RegWriteW", 32'(RegWriteW), 32'd0);
    op(1, 1, 3, 0);
    step();
    chk("post-wrap InstRetW", InstRetW, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
